// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone master state type and bus width defaults
package wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RETRY,
        RESP
    } wb_state_t;

endpackage

// File: rtl/wb_master_ctrl.sv
// rtl/wb_master_ctrl.sv - single-transfer Wishbone B3 classic bus master
module wb_master_ctrl
    import wb_pkg::*;
#(
    parameter int AW        = WB_AW,
    parameter int DW        = WB_DW,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            rst,
    output logic [AW-1:0]   adr,
    input  logic [DW-1:0]   din,
    output logic [DW-1:0]   dout,
    output logic            cyc,
    output logic            stb,
    output logic [DW/8-1:0] sel,
    output logic            we,
    input  logic            ack,
    input  logic            err,
    input  logic            rty,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW/8-1:0] cmd_sel,
    input  logic [DW-1:0]   cmd_wdata,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            rsp_tmo
);

    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    wb_state_t         state, state_next;
    logic [RCW-1:0]    retry_cnt, retry_next;
    logic [WCW-1:0]    wait_cnt, wait_next;
    logic              cyc_next, valid_next, err_next, tmo_next, we_next;
    logic [AW-1:0]     adr_next;
    logic [DW-1:0]     dout_next, rdata_next;
    logic [DW/8-1:0]   sel_next;
    logic              tmo_hit, retry_spent;

    // Abort fires on the edge closing the TIMEOUT-th strobed cycle with no reply.
    assign tmo_hit     = (TIMEOUT != 0) && (wait_cnt == WCW'(TIMEOUT - 1));
    assign retry_spent = (retry_cnt == RCW'(MAX_RETRY));

    assign stb       = cyc;
    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_next = state;
        cyc_next   = cyc;
        wait_next  = wait_cnt;
        retry_next = retry_cnt;
        adr_next   = adr;
        dout_next  = dout;
        sel_next   = sel;
        we_next    = we;
        rdata_next = rsp_rdata;
        err_next   = rsp_err;
        tmo_next   = rsp_tmo;
        valid_next = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = BUS;
                    cyc_next   = 1'b1;
                    adr_next   = cmd_adr;
                    sel_next   = cmd_sel;
                    we_next    = cmd_we;
                    dout_next  = cmd_we ? cmd_wdata : '0;
                    wait_next  = '0;
                    retry_next = '0;
                end
            end
            BUS: begin
                if (ack) begin
                    if (!we) begin
                        rdata_next = din;
                    end
                    cyc_next   = 1'b0;
                    state_next = RESP;
                    valid_next = 1'b1;
                    err_next   = 1'b0;
                    tmo_next   = 1'b0;
                end else if (err || (rty && retry_spent)) begin
                    cyc_next   = 1'b0;
                    state_next = RESP;
                    valid_next = 1'b1;
                    err_next   = 1'b1;
                    tmo_next   = 1'b0;
                end else if (rty) begin
                    cyc_next   = 1'b0;
                    state_next = RETRY;
                    retry_next = retry_cnt + 1'b1;
                end else if (tmo_hit) begin
                    cyc_next   = 1'b0;
                    state_next = RESP;
                    valid_next = 1'b1;
                    err_next   = 1'b1;
                    tmo_next   = 1'b1;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            RETRY: begin
                state_next = BUS;
                cyc_next   = 1'b1;
                wait_next  = '0;
            end
            RESP: begin
                state_next = IDLE;
                err_next   = 1'b0;
                tmo_next   = 1'b0;
            end
            default: begin
                state_next = IDLE;
                cyc_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cyc       <= 1'b0;
            wait_cnt  <= '0;
            retry_cnt <= '0;
            adr       <= '0;
            dout      <= '0;
            sel       <= '0;
            we        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_tmo   <= 1'b0;
        end else begin
            state     <= state_next;
            cyc       <= cyc_next;
            wait_cnt  <= wait_next;
            retry_cnt <= retry_next;
            adr       <= adr_next;
            dout      <= dout_next;
            sel       <= sel_next;
            we        <= we_next;
            rsp_valid <= valid_next;
            rsp_rdata <= rdata_next;
            rsp_err   <= err_next;
            rsp_tmo   <= tmo_next;
        end
    end

endmodule

// File: tb/tb_wb_master_ctrl.sv
// tb/tb_wb_master_ctrl.sv - self-checking bench for wb_master_ctrl
module tb_wb_master_ctrl;

    localparam int TMO  = 8;
    localparam int MAXR = 3;
    localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_BOTH = 3, K_NONE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, din, dout, cmd_adr, cmd_wdata, rsp_rdata;
    logic        cyc, stb, we, ack, err, rty;
    logic [3:0]  sel, cmd_sel;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic        rsp_valid, rsp_err, rsp_tmo;

    int          checks = 0;
    int          failures = 0;
    int          kind [0:7];
    int          wt [0:7];
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    wb_master_ctrl #(.AW(32), .DW(32), .MAX_RETRY(MAXR), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .adr(adr), .din(din), .dout(dout), .cyc(cyc), .stb(stb),
        .sel(sel), .we(we), .ack(ack), .err(err), .rty(rty),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
        .cmd_sel(cmd_sel), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_script();
        for (int i = 0; i < 8; i++) begin
            kind[i] = K_ACK;
            wt[i]   = 0;
        end
    endtask

    task automatic run_txn(input string tag, input logic t_we, input logic [31:0] t_adr,
                           input logic [3:0] t_sel, input logic [31:0] t_wd,
                           input logic [31:0] t_rd);
        int m_high = 0, m_issues = 1, m_err = 0, m_tmo = 0;
        logic [31:0] m_rdata = exp_rdata;
        int o_high = 0, o_issues = 0, o_pulses = 0, o_err = 0, o_tmo = 0;
        logic [31:0] o_rdata = '0;
        int bus_bad = 0, gap_bad = 0, rdy_bad = 0, lat_bad = 0;
        int zrun = 0, cnt = 0, att = -1, post = -1;
        logic pcyc = 1'b0;

        // Outcome from the slave script: each attempt lasts wt+1 cycles unless the timeout wins.
        for (int a = 0; a < 8; a++) begin
            if (kind[a] == K_NONE || wt[a] >= TMO) begin
                m_high += TMO; m_err = 1; m_tmo = 1; break;
            end
            m_high += wt[a] + 1;
            if (kind[a] == K_ACK || kind[a] == K_BOTH) begin
                if (!t_we) m_rdata = t_rd;
                break;
            end
            if (kind[a] == K_ERR || a == MAXR) begin
                m_err = 1; break;
            end
            m_issues++;
        end
        exp_rdata = m_rdata;

        @(negedge clk);
        check({tag, "_idle_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_we = t_we; cmd_adr = t_adr; cmd_sel = t_sel; cmd_wdata = t_wd;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_adr = $urandom; cmd_sel = 4'($urandom); cmd_wdata = $urandom;
        cmd_we = 1'($urandom);
        check({tag, "_first_cyc"}, cyc, 1);

        for (int n = 0; n < 300 && post != 0; n++) begin
            if (n > 0) @(negedge clk);
            if (cyc) begin
                if (!pcyc) begin
                    o_issues++; att++; cnt = 0;
                    if (o_issues > 1 && zrun != 1) gap_bad = 1;
                end
                cnt++; o_high++;
                if (stb !== 1'b1 || adr !== t_adr || sel !== t_sel || we !== t_we ||
                    dout !== (t_we ? t_wd : 32'h0)) bus_bad = 1;
                if (cmd_ready !== 1'b0) rdy_bad = 1;
            end else begin
                if (pcyc) zrun = 0;
                zrun++;
                if (stb !== 1'b0) bus_bad = 1;
            end
            if (rsp_valid) begin
                o_pulses++;
                if (o_pulses == 1) begin
                    o_err = int'(rsp_err); o_tmo = int'(rsp_tmo); o_rdata = rsp_rdata;
                    if (!pcyc || cyc) lat_bad = 1;
                    post = 2;
                end
            end
            if (post > 0) post--;
            ack = 1'b0; err = 1'b0; rty = 1'b0; din = $urandom;
            if (cyc) begin
                if (att < 8 && kind[att] != K_NONE && cnt == wt[att] + 1) begin
                    case (kind[att])
                        K_ACK:   begin ack = 1'b1; din = t_rd; end
                        K_BOTH:  begin ack = 1'b1; err = 1'b1; rty = 1'b1; din = t_rd; end
                        K_ERR:   err = 1'b1;
                        default: rty = 1'b1;
                    endcase
                end
            end else begin
                {ack, err, rty} = 3'($urandom);
            end
            pcyc = cyc;
        end
        check({tag, "_ready_after"}, cmd_ready, 1);
        ack = 1'b0; err = 1'b0; rty = 1'b0;

        check({tag, "_pulses"}, o_pulses, 1);
        check({tag, "_err"}, o_err, m_err);
        check({tag, "_tmo"}, o_tmo, m_tmo);
        check({tag, "_rdata"}, o_rdata, exp_rdata);
        check({tag, "_cyc_high"}, o_high, m_high);
        check({tag, "_issues"}, o_issues, m_issues);
        check({tag, "_bus_stable"}, bus_bad, 0);
        check({tag, "_gap_1cyc"}, gap_bad, 0);
        check({tag, "_ready_low"}, rdy_bad, 0);
        check({tag, "_rsp_latency"}, lat_bad, 0);
    endtask

    initial begin
        int bad;
        rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0;
        cmd_wdata = '0; ack = 1'b0; err = 1'b0; rty = 1'b0; din = '0;
        exp_rdata = '0;
        #12;
        check("rst_cyc", {cyc, stb, we}, 3'b000);
        check("rst_bus", {adr, dout, sel}, '0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_tmo, rsp_rdata}, '0);
        @(negedge clk);
        rst = 1'b1;

        clr_script();
        run_txn("wr_zero_wait", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
        clr_script(); wt[0] = 3;
        run_txn("rd_3wait", 1'b0, 32'h14, 4'h1, 32'h0, 32'h000000A5);
        clr_script(); kind[0] = K_RTY; kind[1] = K_RTY;
        run_txn("rty2_ack", 1'b0, 32'h18, 4'h3, 32'h0, 32'h12345678);
        clr_script(); kind[0] = K_RTY; kind[1] = K_RTY; kind[2] = K_RTY; kind[3] = K_RTY;
        run_txn("rty_exhaust", 1'b0, 32'h1C, 4'hF, 32'h0, 32'hCAFEF00D);
        clr_script(); kind[0] = K_ERR;
        run_txn("err_first", 1'b0, 32'h20, 4'hF, 32'h0, 32'h55AA55AA);
        clr_script(); kind[0] = K_NONE;
        run_txn("timeout", 1'b1, 32'h24, 4'hC, 32'h0BADF00D, 32'h0);
        clr_script(); wt[0] = TMO - 1;
        run_txn("ack_at_limit", 1'b0, 32'h28, 4'hF, 32'h0, 32'h0000BEEF);
        clr_script(); wt[0] = TMO;
        run_txn("ack_past_limit", 1'b0, 32'h2C, 4'hF, 32'h0, 32'h11112222);
        clr_script(); kind[0] = K_BOTH;
        run_txn("ack_and_err", 1'b0, 32'h30, 4'h2, 32'h0, 32'h87654321);

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 8; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                kind[i] = (r < 4) ? K_ACK : (r == 4) ? K_ERR : (r < 8) ? K_RTY :
                          (r == 8) ? K_BOTH : K_NONE;
                wt[i] = int'($urandom_range(0, 9));
            end
            run_txn("rand", 1'($urandom), $urandom, 4'($urandom), $urandom, $urandom);
        end

        clr_script(); kind[0] = K_NONE;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h40; cmd_sel = 4'hF; cmd_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_cyc_before", cyc, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_cyc", {cyc, stb, we}, 3'b000);
        check("mid_rst_bus", {adr, dout, sel}, '0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cyc !== 1'b0) bad = 1;
        end
        rst = 1'b1;
        @(negedge clk);
        if (rsp_valid !== 1'b0 || cyc !== 1'b0) bad = 1;
        check("mid_rst_no_rsp", bad, 0);
        check("mid_rst_ready", cmd_ready, 1);
        exp_rdata = '0;
        check("mid_rst_rdata", rsp_rdata, exp_rdata);
        clr_script(); wt[0] = 1;
        run_txn("post_rst_rd", 1'b0, 32'h44, 4'hF, 32'h0, 32'hFEEDFACE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
